uart_rx_fifo: RTL
=================

# uart_rx_fifo

Serial receive front end for the MIPS150 system. Sits between the `FPGA_SERIAL_RX` pin and the CPU's memory-mapped UART receive register. Deserialises 8N1 frames, checks start/stop bits, and buffers received bytes in a first-word-fall-through FIFO. The CPU drains the FIFO with a valid/ready handshake.

## Interface
- `CLOCK_FREQ`, default 50_000_000: clk frequency in Hz.
- `BAUD_RATE`, default 115_200: line rate in bits/s. `SYMBOL_EDGE_TIME = CLOCK_FREQ/BAUD_RATE` (integer division) clocks per bit.
- `FIFO_DEPTH`, default 8: byte entries. Must be a power of two, ≥ 2.

- `clk`  in  1  sole clock; all state changes on rising edge.
- `rst`  in  1  synchronous reset, active-low; sampled on the rising edge of `clk`.
- `serial_in`  in  1  asynchronous RX line; idles high.
- `data_out`  out  8  byte at the FIFO head. Don't-care while `data_out_valid`=0.
- `data_out_valid`  out  1  FIFO non-empty.
- `data_out_ready`  in  1  consumer accepts the head byte this cycle.
- `framing_error`  out  1  one-cycle pulse: stop bit sampled low.
- `overflow`  out  1  one-cycle pulse: a good byte was dropped because the FIFO was full.
- `fifo_count`  out  log2(FIFO_DEPTH)+1  current occupancy.

## Operation
- Input path:
  - `serial_in` passes through a two-flop synchroniser; the result is `rx_s`.
  - All line decisions use `rx_s` only.
- Receiver FSM, clocked by bit counter `clk_cnt` (0..SYMBOL_EDGE_TIME-1) and bit index `bit_idx` (0..7). `MID` = SYMBOL_EDGE_TIME/2.
  - IDLE:
    - If `rx_s`=0: go to START with `clk_cnt`=0.
  - START:
    - At `clk_cnt`=MID, if `rx_s`=1: false start, go to IDLE.
    - At `clk_cnt`=MID, if `rx_s`=0: reset `clk_cnt`, go to DATA with `bit_idx`=0.
  - DATA:
    - Every SYMBOL_EDGE_TIME clocks (i.e. mid-bit), sample `rx_s` into `shift[bit_idx]`. LSB first.
    - After bit 7, go to STOP.
  - STOP:
    - At mid-bit, if `rx_s`=1: push `shift` to the FIFO if it is not full; otherwise pulse `overflow` and drop the byte. Go to IDLE.
    - At mid-bit, if `rx_s`=0: pulse `framing_error`, discard the byte, go to BREAK.
  - BREAK:
    - Stay until `rx_s`=1, then go to IDLE. A held-low line never produces further frames.
- FIFO:
  - Circular buffer with read/write pointers of log2(FIFO_DEPTH) bits that wrap modulo FIFO_DEPTH.
  - A separate `fifo_count` tracks occupancy.
  - Pop when `data_out_valid && data_out_ready`.
  - Push when the STOP check passes and the FIFO is not full.
  - Push and pop in the same cycle while full: the pop frees a slot, so the push is accepted and `fifo_count` is unchanged.
  - Push and pop in the same cycle while non-empty and not full: both happen and the count is unchanged.
  - `data_out_ready` while empty is ignored.
- Reset (`rst`=0 at an edge), including mid-frame or with a full FIFO:
  - FSM returns to IDLE.
  - Counters, pointers and `fifo_count` are cleared.
  - `data_out_valid`=0, `framing_error`=0, `overflow`=0.
  - Synchroniser flops are set to 1.
  - FIFO contents are discarded; `data_out` becomes don't-care.
  - A frame in flight is lost.
  - After release, reception resumes on the next falling edge of `rx_s`.

## Timing
- Synchroniser latency: 2 clocks from a `serial_in` change to `rx_s`.
- Sample points:
  - Start bit is checked MID clocks after its falling edge is seen on `rx_s`.
  - Each later bit is sampled SYMBOL_EDGE_TIME clocks after the previous sample.
- The FIFO write occurs on the edge of the stop-bit sample. `data_out_valid` rises on the next cycle; `data_out` is valid in that same cycle (first-word fall-through).
- The pop takes effect on the handshake edge. The next entry, or `data_out_valid`=0, appears in the following cycle.
- `framing_error` and `overflow` are registered and high for exactly one cycle, the cycle after the stop-bit sample.
- Back-to-back frames (a start bit immediately following the stop bit) must be received without loss. The FSM is back in IDLE at mid-stop-bit, half a bit before the next start edge.

## Test plan
Benches use CLOCK_FREQ=100, BAUD_RATE=10 (SYMBOL_EDGE_TIME=10), FIFO_DEPTH=4.

1. Single frame 0xA5 with `data_out_ready`=0 → `data_out_valid` rises about 96 clocks after the start edge with `data_out`=0xA5 and `fifo_count`=1. Assert ready for one cycle → valid=0 and count=0 next cycle.
2. Four back-to-back frames 0x01, 0x02, 0x03, 0x04 with ready=0, then ready held at 1 → bytes pop in order 0x01..0x04, one per cycle. No errors.
3. Five frames while ready=0 → `fifo_count`=4. On the fifth stop bit `overflow` pulses for 1 cycle. Head remains 0x01 and the fifth byte is absent.
4. Frame 0x3C sent with a stop bit of 0, line then held low for 30 clocks before idling high → `framing_error` pulses once, no push, and FSM stays in BREAK. A following 0x55 frame is received correctly.
5. Line glitch low for 3 clocks → false start rejected. No push, no error pulses.
6. `rst`=0 for one cycle at data bit 4 of a frame while the FIFO holds 2 bytes → next cycle: valid=0, `fifo_count`=0, no pulses. A subsequent 0x7E frame is received as the only entry.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - received-byte stream handshake between UART RX and its consumer
interface uart_rx_fifo_if;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready;

  modport master (output data_out, output data_out_valid, input data_out_ready);
  modport slave  (input data_out, input data_out_valid, output data_out_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 serial receiver feeding a first-word-fall-through byte FIFO
module uart_rx_fifo #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          serial_in,
  uart_rx_fifo_if.master                rx_if,
  output logic                          framing_error,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int SET   = CLOCK_FREQ / BAUD_RATE;
  localparam int CNT_W = $clog2(SET + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam logic [CNT_W-1:0] MID_C = CNT_W'(SET / 2);
  localparam logic [CNT_W-1:0] END_C = CNT_W'(SET - 1);
  localparam logic [CW-1:0]    FULL_C = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t           state, state_nxt;
  logic             sync1, rx_s;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;

  logic mid_hit, bit_end;
  logic cnt_inc, bit_sample, push_req, ferr_req;
  logic full, push, pop;

  assign mid_hit = (clk_cnt == MID_C);
  assign bit_end = (clk_cnt == END_C);

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!rx_s)                      state_nxt = S_START;
      S_START: if (mid_hit)                    state_nxt = rx_s ? S_IDLE : S_DATA;
      S_DATA:  if (bit_end && bit_idx == 3'd7) state_nxt = S_STOP;
      S_STOP:  if (bit_end)                    state_nxt = rx_s ? S_IDLE : S_BREAK;
      S_BREAK: if (rx_s)                       state_nxt = S_IDLE;
      default:                                 state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_inc    = 1'b0;
    bit_sample = 1'b0;
    push_req   = 1'b0;
    ferr_req   = 1'b0;
    case (state)
      S_START: cnt_inc = !mid_hit;
      S_DATA: begin
        cnt_inc    = !bit_end;
        bit_sample = bit_end;
      end
      S_STOP: begin
        cnt_inc  = !bit_end;
        push_req = bit_end && rx_s;
        ferr_req = bit_end && !rx_s;
      end
      default: ;
    endcase
  end

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign pop  = rx_if.data_out_valid && rx_if.data_out_ready;
  assign full = (fifo_count == FULL_C);
  assign push = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1         <= 1'b1;
      rx_s          <= 1'b1;
      clk_cnt       <= '0;
      bit_idx       <= '0;
      shift         <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_count    <= '0;
      framing_error <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      sync1         <= serial_in;
      rx_s          <= sync1;
      clk_cnt       <= cnt_inc ? clk_cnt + 1'b1 : '0;
      framing_error <= ferr_req;
      overflow      <= push_req && !push;
      if (state != S_DATA)  bit_idx <= '0;
      else if (bit_sample)  bit_idx <= bit_idx + 1'b1;
      if (bit_sample) shift[bit_idx] <= rx_s;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shift;
  end

  assign rx_if.data_out       = mem[rd_ptr];
  assign rx_if.data_out_valid = (fifo_count != '0);
endmodule
